spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
- SPI peripheral (mode 0, write-only) that configures the project's output-enable and PWM datapath. It sits between ui_in pins (SCLK/COPI/nCS) and the PWM/output mux inside the top-level tt_um wrapper.
- Receives 16-bit write transactions, decodes the address and commits the data byte into one of five configuration registers.
- All SPI inputs are asynchronous to clk and are synchronised internally.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each SPI input before use (minimum 2).
- MAX_ADDR, 7'h04, highest valid register address; writes above it are dropped.

Ports:
- clk  input  1  system clock (10 MHz nominal).
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock, async; idle low.
- copi  input  1  SPI data in, async; sampled on sclk rising edge.
- ncs  input  1  SPI chip select, async, active-low.
- en_reg_out_7_0  output  8  register 0x00: uo_out enables.
- en_reg_out_15_8  output  8  register 0x01: uio_out enables.
- en_reg_pwm_7_0  output  8  register 0x02: uo_out PWM mode select.
- en_reg_pwm_15_8  output  8  register 0x03: uio_out PWM mode select.
- pwm_duty_cycle  output  8  register 0x04: PWM duty (0x00 = 0 %, 0xFF = 100 %).
- busy  output  1  high while a transaction is in progress (state SHIFT).

Behaviour:
- Reset: all five register outputs = 8'h00, busy = 0, shift register and bit counter cleared, state IDLE, synchroniser flops set to the idle pattern (sclk = 0, ncs = 1) so no false edge is seen after reset.
- Synchronisation and edge detection:
  - Each input passes through SYNC_STAGES flops, then one history flop for edge detection.
  - sclk_rise = synced & ~hist. ncs_fall and ncs_rise are derived the same way.
  - Requirement on the bus: sclk high and low phases each ≥ 4 clk periods.
- Frame format, MSB first, 16 bits: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- FSM:
  - IDLE: on ncs_fall, clear the counter and shift register and go to SHIFT.
  - SHIFT: on each sclk_rise, shift in copi and increment the counter, saturating at 17. On ncs_rise, go to COMMIT.
  - COMMIT: lasts one cycle. A write occurs only if count == 16 AND R/W == 1 AND address ≤ MAX_ADDR. Always return to IDLE.
- Latency: the selected register updates on the clk edge that ends COMMIT, which is SYNC_STAGES + 2 clk cycles after raw ncs rises (4 with the default). The updated value is visible from that edge onward.
- Boundary conditions:
  - Fewer than 16 or more than 16 sclk edges: frame discarded, no register changes.
  - R/W = 0: discarded; reads are not supported and there is no CIPO.
  - Address > MAX_ADDR: discarded silently.
  - sclk_rise in the same cycle as ncs_rise: the edge is ignored and ncs_rise takes priority.
  - ncs_fall while in SHIFT cannot occur without an intervening rise; no special handling.
  - sclk edges while ncs is high: ignored.
  - rst asserted mid-frame: immediate return to reset state on the next clk edge; the partial frame is lost and registers clear to 0.
- busy = (state == SHIFT), registered.
- Non-selected registers hold their values.

Decomposition:
- Package spi_reg_pkg:
  - constants FRAME_BITS = 16, ADDR_W = 7, DATA_W = 8.
  - register addresses ADDR_EN_OUT_LO = 0x00 … ADDR_PWM_DUTY = 0x04.
  - state enum {IDLE, SHIFT, COMMIT}.
- Sub-module spi_sync_edge: parameter SYNC_STAGES, reset idle value. Inputs async_in; outputs level, rise, fall. Instantiated three times (sclk, copi, ncs); copi uses only level.

Test Plan:
- Reset: assert rst for 5 cycles → all five registers = 0x00, busy = 0.
- Write 0x80F0 (addr 0x00, data 0xF0) → en_reg_out_7_0 = 0xF0 exactly 4 clk after ncs rises; other registers remain 0x00.
- Write 0x8480 (addr 0x04, data 0x80) → pwm_duty_cycle = 0x80. Then write 0x0455 (R/W = 0) → pwm_duty_cycle stays 0x80.
- Write 0x85AA (addr 0x05 > MAX_ADDR) → no register changes. Then a 15-bit frame and a 17-bit frame carrying 0x80FF → en_reg_out_7_0 unchanged.
- Back-to-back frames 0x81CC and 0x8233, with ncs high for 5 clk between them → en_reg_out_15_8 = 0xCC and en_reg_pwm_7_0 = 0x33.
- Assert rst after 9 bits of 0x83FF → busy drops, registers = 0x00. Then a full 0x83FF frame → en_reg_pwm_15_8 = 0xFF.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared constants, register map and FSM state type for the SPI configuration block.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned CNT_W      = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = 5'd16;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd17;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCommit
  } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one async input plus a history flop for edge detection.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Reset to the bus idle level so no spurious edge follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_ctrl.sv
// Write-only SPI mode-0 slave committing 16-bit frames into five configuration registers.
module spi_reg_ctrl
  import spi_reg_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [ADDR_W-1:0] MAX_ADDR    = 7'h04
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              copi,
  input  logic              ncs,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              busy
);

  logic sclk_rise, copi_level, ncs_rise, ncs_fall;
  logic unused_sclk_level, unused_sclk_fall, unused_copi_rise, unused_copi_fall, unused_ncs_level;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_in(sclk),
    .level(unused_sclk_level), .rise(sclk_rise), .fall(unused_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .async_in(copi),
    .level(copi_level), .rise(unused_copi_rise), .fall(unused_copi_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .async_in(ncs),
    .level(unused_ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;

  assign wr_addr = shreg_q[FRAME_BITS-2 -: ADDR_W];
  assign wr_data = shreg_q[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    wr_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ncs_fall) begin
          cnt_d   = '0;
          shreg_d = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // A deselect in the same cycle as an sclk edge wins; that edge is dropped.
        if (ncs_rise) begin
          state_d = StCommit;
        end else if (sclk_rise) begin
          shreg_d = {shreg_q[FRAME_BITS-2:0], copi_level};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      StCommit: begin
        wr_en   = (cnt_q == CNT_FULL) && shreg_q[FRAME_BITS-1] && (wr_addr <= MAX_ADDR);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_EN_OUT_LO: en_reg_out_7_0  <= wr_data;
        ADDR_EN_OUT_HI: en_reg_out_15_8 <= wr_data;
        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= wr_data;
        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= wr_data;
        ADDR_PWM_DUTY:  pwm_duty_cycle  <= wr_data;
        default: ;
      endcase
    end
  end

  assign busy = (state_q == StShift);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: directed and random SPI frames against a register-map model.
module tb_spi_reg_ctrl;

  localparam int HALF = 5;

  logic       clk = 1'b0;
  logic       rst, sclk, copi, ncs;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_regs [5];
  logic [7:0] dut_regs [5];

  spi_reg_ctrl dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .busy(busy)
  );

  always #5 clk = ~clk;

  assign dut_regs[0] = en_reg_out_7_0;
  assign dut_regs[1] = en_reg_out_15_8;
  assign dut_regs[2] = en_reg_pwm_7_0;
  assign dut_regs[3] = en_reg_pwm_15_8;
  assign dut_regs[4] = pwm_duty_cycle;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bits are right-aligned; frame MSB is bits[nbits-1]. The model commits only a
  // full 16-bit write frame to an address in 0..4, four clocks after ncs rises.
  task automatic send_frame(input logic [16:0] bits, input int nbits, input string name);
    logic accept;
    int   addr;
    tick(1);
    ncs = 1'b0;
    tick(HALF);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(HALF);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_in_frame: got %b want 1", name, busy);
    end
    ncs = 1'b0 | 1'b1;
    tick(3);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== exp_regs[r]) begin
        errors++;
        $display("FAIL %s early_reg%0d: got %h want %h", name, r, dut_regs[r], exp_regs[r]);
      end
    end
    addr   = int'(bits[14:8]);
    accept = (nbits == 16) && bits[15] && (addr <= 4);
    if (accept) exp_regs[addr] = bits[7:0];
    tick(1);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== exp_regs[r]) begin
        errors++;
        $display("FAIL %s reg%0d: got %h want %h", name, r, dut_regs[r], exp_regs[r]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after: got %b want 0", name, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    for (int r = 0; r < 5; r++) exp_regs[r] = 8'h00;
    tick(2);
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== 8'h00) begin
        errors++;
        $display("FAIL reset reg%0d: got %h want 00", r, dut_regs[r]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset busy: got %b want 0", busy);
    end
  endtask

  task automatic test_write;
    send_frame(17'h080F0, 16, "wr_out_lo");
    checks++;
    if (en_reg_out_7_0 !== 8'hF0) begin
      errors++;
      $display("FAIL wr_out_lo value: got %h want f0", en_reg_out_7_0);
    end
    send_frame(17'h08480, 16, "wr_duty");
    send_frame(17'h00455, 16, "read_dropped");
    checks++;
    if (pwm_duty_cycle !== 8'h80) begin
      errors++;
      $display("FAIL read_dropped duty: got %h want 80", pwm_duty_cycle);
    end
  endtask

  task automatic test_discard;
    send_frame(17'h085AA, 16, "bad_addr");
    send_frame(17'h080FF >> 1, 15, "short_frame");
    send_frame({17'h080FF, 1'b1} >> 1 | 17'h10000, 17, "long_frame");
    checks++;
    if (en_reg_out_7_0 !== 8'hF0) begin
      errors++;
      $display("FAIL discard out_lo: got %h want f0", en_reg_out_7_0);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(17'h081CC, 16, "b2b_first");
    send_frame(17'h08233, 16, "b2b_second");
    checks++;
    if (en_reg_out_15_8 !== 8'hCC || en_reg_pwm_7_0 !== 8'h33) begin
      errors++;
      $display("FAIL b2b values: got %h/%h want cc/33", en_reg_out_15_8, en_reg_pwm_7_0);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] frame;
    frame = 16'h83FF;
    tick(1);
    ncs = 1'b0;
    tick(HALF);
    for (int i = 15; i >= 7; i--) begin
      copi = frame[i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst busy_before: got %b want 1", busy);
    end
    rst = 1'b1;
    tick(1);
    for (int r = 0; r < 5; r++) exp_regs[r] = 8'h00;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst busy: got %b want 0", busy);
    end
    for (int r = 0; r < 5; r++) begin
      checks++;
      if (dut_regs[r] !== 8'h00) begin
        errors++;
        $display("FAIL midrst reg%0d: got %h want 00", r, dut_regs[r]);
      end
    end
    ncs = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    send_frame(17'h083FF, 16, "after_rst");
    checks++;
    if (en_reg_pwm_15_8 !== 8'hFF) begin
      errors++;
      $display("FAIL after_rst pwm_hi: got %h want ff", en_reg_pwm_15_8);
    end
  endtask

  task automatic test_random;
    logic [16:0] bits;
    int          nbits;
    int          pick;
    for (int k = 0; k < 24; k++) begin
      pick  = int'($urandom_range(0, 5));
      nbits = (pick == 0) ? 15 : (pick == 1) ? 17 : 16;
      bits  = 17'($urandom);
      bits[15] = ($urandom_range(0, 3) != 0);
      bits[14:8] = 7'($urandom_range(0, 7));
      if (nbits == 15) bits[16:15] = 2'b00;
      if (nbits == 16) bits[16] = 1'b0;
      send_frame(bits, nbits, "random");
    end
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    test_reset;
    test_write;
    test_discard;
    test_back_to_back;
    test_reset_mid_frame;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
